cpu_control_fsm: RTL and testbench

Multicycle sequencer for the CPU datapath. It drives instruction fetch, the register file's two-cycle read path, ALU execute, data-memory access and register write-back. It owns the `i_load` strobe of the register file, the IR and PC load enables, and the memory request handshake. It sits beside the register file and ALU, and is the only block that advances architectural state.

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/cpu_opcode_decode.sv | 68 ++++++
 rtl/cpu_control_fsm.sv | 106 ++++++++++
 tb/tb_cpu_control_fsm.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, sequencer
// states, write-back and next-PC selects, and the opcode decode record.
package cpu_pkg;

  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned INSTRET_W = 32;

  localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET = 3'd0,
    ST_FETCH = 3'd1,
    ST_DEC1  = 3'd2,
    ST_DEC2  = 3'd3,
    ST_EXEC  = 3'd4,
    ST_MEM   = 3'd5,
    ST_WB    = 3'd6,
    ST_TRAP  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_REL = 2'd1,
    PC_ALU = 2'd2
  } pc_sel_e;

  // How the next PC is chosen; BRANCH defers to the registered comparator flag.
  typedef enum logic [1:0] {
    PCC_SEQ    = 2'd0,
    PCC_JAL    = 2'd1,
    PCC_JALR   = 2'd2,
    PCC_BRANCH = 2'd3
  } pc_class_e;

  typedef struct packed {
    logic      legal;
    logic      writes_rd;
    logic      is_mem;
    logic      is_store;
    logic      use_imm;
    wb_sel_e   wb_sel;
    pc_class_e pc_class;
  } dec_t;

endpackage

// File: rtl/cpu_opcode_decode.sv
// Combinational opcode classifier feeding the control sequencer.
module cpu_opcode_decode
  import cpu_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output dec_t                dec
);

  always_comb begin
    dec          = '0;
    dec.wb_sel   = WB_ALU;
    dec.pc_class = PCC_SEQ;
    case (opcode)
      OPC_LUI: begin
        dec.legal     = 1'b1;
        dec.writes_rd = 1'b1;
        dec.use_imm   = 1'b1;
        dec.wb_sel    = WB_IMM;
      end
      OPC_AUIPC, OPC_OP_IMM: begin
        dec.legal     = 1'b1;
        dec.writes_rd = 1'b1;
        dec.use_imm   = 1'b1;
      end
      OPC_JAL: begin
        dec.legal     = 1'b1;
        dec.writes_rd = 1'b1;
        dec.use_imm   = 1'b1;
        dec.wb_sel    = WB_PC4;
        dec.pc_class  = PCC_JAL;
      end
      OPC_JALR: begin
        dec.legal     = 1'b1;
        dec.writes_rd = 1'b1;
        dec.use_imm   = 1'b1;
        dec.wb_sel    = WB_PC4;
        dec.pc_class  = PCC_JALR;
      end
      OPC_BRANCH: begin
        dec.legal    = 1'b1;
        dec.pc_class = PCC_BRANCH;
      end
      OPC_LOAD: begin
        dec.legal     = 1'b1;
        dec.writes_rd = 1'b1;
        dec.is_mem    = 1'b1;
        dec.use_imm   = 1'b1;
        dec.wb_sel    = WB_MEM;
      end
      OPC_STORE: begin
        dec.legal    = 1'b1;
        dec.is_mem   = 1'b1;
        dec.is_store = 1'b1;
        dec.use_imm  = 1'b1;
      end
      OPC_OP: begin
        dec.legal     = 1'b1;
        dec.writes_rd = 1'b1;
      end
      OPC_FENCE: begin
        dec.legal   = 1'b1;
        dec.use_imm = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle sequencer: fetch, two-cycle register read, execute, memory
// access and write-back, with retired-instruction counting and illegal trap.
module cpu_control_fsm
  import cpu_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [OPCODE_W-1:0]  i_opcode,
  input  logic                 i_branch_taken,
  input  logic                 i_mem_ack,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic                 o_addr_sel,
  output logic                 o_ir_load,
  output logic                 o_rf_load,
  output logic [1:0]           o_wb_sel,
  output logic                 o_alu_src_b,
  output logic                 o_pc_load,
  output logic [1:0]           o_pc_sel,
  output logic                 o_fault,
  output logic [INSTRET_W-1:0] o_instret
);

  state_e                state_q, state_d;
  logic                  branch_q;
  logic [INSTRET_W-1:0]  instret_q;
  dec_t                  dec;

  cpu_opcode_decode u_decode (
    .opcode (i_opcode),
    .dec    (dec)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: if (i_mem_ack) state_d = ST_DEC1;
      ST_DEC1:  state_d = ST_DEC2;
      ST_DEC2:  state_d = dec.legal ? ST_EXEC : ST_TRAP;
      ST_EXEC:  state_d = dec.is_mem ? ST_MEM : ST_WB;
      ST_MEM:   if (i_mem_ack) state_d = ST_WB;
      ST_WB:    state_d = ST_FETCH;
      ST_TRAP:  state_d = ST_TRAP;
      default:  state_d = ST_RESET;
    endcase
  end

  // Comparator result is captured as EXEC exits so WB sees a stable decision.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  branch_q <= 1'b0;
    else if (state_q == ST_EXEC) branch_q <= i_branch_taken;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                instret_q <= '0;
    else if (state_q == ST_WB) instret_q <= instret_q + INSTRET_W'(1);
  end

  assign o_instret = instret_q;

  // Moore decode; only o_ir_load looks at the live ack, and only in FETCH.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_addr_sel  = 1'b0;
    o_ir_load   = 1'b0;
    o_rf_load   = 1'b0;
    o_wb_sel    = WB_ALU;
    o_alu_src_b = 1'b0;
    o_pc_load   = 1'b0;
    o_pc_sel    = PC_SEQ;
    o_fault     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        o_mem_req = 1'b1;
        o_ir_load = i_mem_ack;
      end
      ST_EXEC: o_alu_src_b = dec.use_imm;
      ST_MEM: begin
        o_mem_req  = 1'b1;
        o_addr_sel = 1'b1;
        o_mem_we   = dec.is_store;
      end
      ST_WB: begin
        o_pc_load = 1'b1;
        o_rf_load = dec.writes_rd;
        o_wb_sel  = dec.wb_sel;
        case (dec.pc_class)
          PCC_JAL:    o_pc_sel = PC_REL;
          PCC_JALR:   o_pc_sel = PC_ALU;
          PCC_BRANCH: o_pc_sel = branch_q ? PC_REL : PC_SEQ;
          default:    o_pc_sel = PC_SEQ;
        endcase
      end
      ST_TRAP: o_fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: stimulus queues expected per-cycle
// output snapshots, a monitor on the falling edge pops and compares them.
module tb_cpu_control_fsm;

  logic        i_clk;
  logic        i_rst;
  logic [6:0]  i_opcode;
  logic        i_branch_taken;
  logic        i_mem_ack;
  logic        o_mem_req, o_mem_we, o_addr_sel, o_ir_load, o_rf_load;
  logic [1:0]  o_wb_sel;
  logic        o_alu_src_b, o_pc_load;
  logic [1:0]  o_pc_sel;
  logic        o_fault;
  logic [31:0] o_instret;

  cpu_control_fsm dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_opcode       (i_opcode),
    .i_branch_taken (i_branch_taken),
    .i_mem_ack      (i_mem_ack),
    .o_mem_req      (o_mem_req),
    .o_mem_we       (o_mem_we),
    .o_addr_sel     (o_addr_sel),
    .o_ir_load      (o_ir_load),
    .o_rf_load      (o_rf_load),
    .o_wb_sel       (o_wb_sel),
    .o_alu_src_b    (o_alu_src_b),
    .o_pc_load      (o_pc_load),
    .o_pc_sel       (o_pc_sel),
    .o_fault        (o_fault),
    .o_instret      (o_instret)
  );

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_load;
    logic        rf_load;
    logic [1:0]  wb_sel;
    logic        alu_src_b;
    logic        pc_load;
    logic [1:0]  pc_sel;
    logic        fault;
    logic [31:0] instret;
  } vec_t;

  typedef struct {
    vec_t  v;
    string nm;
  } item_t;

  item_t q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  initial i_clk = 1'b1;
  always #5 i_clk = ~i_clk;

  function automatic vec_t v_zero(input logic [31:0] ir);
    vec_t v;
    v = '0;
    v.instret = ir;
    return v;
  endfunction

  function automatic vec_t v_fetch(input logic ack, input logic [31:0] ir);
    vec_t v;
    v = v_zero(ir);
    v.mem_req = 1'b1;
    v.ir_load = ack;
    return v;
  endfunction

  function automatic vec_t v_exec(input logic srcb, input logic [31:0] ir);
    vec_t v;
    v = v_zero(ir);
    v.alu_src_b = srcb;
    return v;
  endfunction

  function automatic vec_t v_mem(input logic we, input logic [31:0] ir);
    vec_t v;
    v = v_zero(ir);
    v.mem_req  = 1'b1;
    v.addr_sel = 1'b1;
    v.mem_we   = we;
    return v;
  endfunction

  function automatic vec_t v_wb(input logic rf, input logic [1:0] wbs,
                                input logic [1:0] pcs, input logic [31:0] ir);
    vec_t v;
    v = v_zero(ir);
    v.pc_load = 1'b1;
    v.rf_load = rf;
    v.wb_sel  = wbs;
    v.pc_sel  = pcs;
    return v;
  endfunction

  function automatic vec_t v_trap(input logic [31:0] ir);
    vec_t v;
    v = v_zero(ir);
    v.fault = 1'b1;
    return v;
  endfunction

  // Drive ack for one cycle and queue the outputs expected in that cycle.
  task automatic step(input logic ack, input vec_t e, input string nm);
    item_t it;
    i_mem_ack = ack;
    it.v  = e;
    it.nm = nm;
    q.push_back(it);
    @(posedge i_clk);
    #1;
  endtask

  // Non-memory instruction, zero-wait fetch: FETCH, DEC1, DEC2, EXEC, WB.
  task automatic run_reg(input logic [6:0] opc, input logic taken, input logic srcb,
                         input logic rf, input logic [1:0] wbs, input logic [1:0] pcs,
                         input logic [31:0] ir, input string nm);
    i_opcode = opc;
    step(1'b1, v_fetch(1'b1, ir), {nm, "_fetch"});
    step(1'b0, v_zero(ir), {nm, "_dec1"});
    step(1'b0, v_zero(ir), {nm, "_dec2"});
    i_branch_taken = taken;
    step(1'b0, v_exec(srcb, ir), {nm, "_exec"});
    i_branch_taken = ~taken;
    step(1'b0, v_wb(rf, wbs, pcs, ir), {nm, "_wb"});
  endtask

  always @(negedge i_clk) begin
    if (q.size() != 0) begin
      item_t it;
      vec_t  got;
      it = q.pop_front();
      got.mem_req   = o_mem_req;
      got.mem_we    = o_mem_we;
      got.addr_sel  = o_addr_sel;
      got.ir_load   = o_ir_load;
      got.rf_load   = o_rf_load;
      got.wb_sel    = o_wb_sel;
      got.alu_src_b = o_alu_src_b;
      got.pc_load   = o_pc_load;
      got.pc_sel    = o_pc_sel;
      got.fault     = o_fault;
      got.instret   = o_instret;
      vectors++;
      if (got !== it.v) begin
        miscompares++;
        $display("FAIL %s: got req=%b we=%b asel=%b ir=%b rf=%b wbs=%0d srcb=%b pcl=%b pcs=%0d flt=%b ret=%0d | want req=%b we=%b asel=%b ir=%b rf=%b wbs=%0d srcb=%b pcl=%b pcs=%0d flt=%b ret=%0d",
                 it.nm, got.mem_req, got.mem_we, got.addr_sel, got.ir_load, got.rf_load,
                 got.wb_sel, got.alu_src_b, got.pc_load, got.pc_sel, got.fault, got.instret,
                 it.v.mem_req, it.v.mem_we, it.v.addr_sel, it.v.ir_load, it.v.rf_load,
                 it.v.wb_sel, it.v.alu_src_b, it.v.pc_load, it.v.pc_sel, it.v.fault, it.v.instret);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors still queued", q.size());
    $fatal(1);
  end

  initial begin
    i_rst          = 1'b1;
    i_mem_ack      = 1'b0;
    i_opcode       = 7'b0000000;
    i_branch_taken = 1'b0;

    // Reset held three cycles, then one RESET cycle, then a request held with no ack.
    for (int i = 0; i < 3; i++) step(1'b0, v_zero(32'd0), "reset_hold");
    i_rst = 1'b0;
    step(1'b0, v_zero(32'd0), "reset_state");
    for (int i = 0; i < 4; i++) step(1'b0, v_fetch(1'b0, 32'd0), "idle_fetch");

    // OP (ADD), zero-wait.
    run_reg(7'b0110011, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 32'd0, "add");
    if (o_instret !== 32'd1) begin
      miscompares++;
      $display("FAIL add_instret: got %0d want 1", o_instret);
    end

    // LOAD with three MEM wait cycles.
    i_opcode = 7'b0000011;
    step(1'b1, v_fetch(1'b1, 32'd1), "load_fetch");
    step(1'b0, v_zero(32'd1), "load_dec1");
    step(1'b0, v_zero(32'd1), "load_dec2");
    step(1'b0, v_exec(1'b1, 32'd1), "load_exec");
    for (int i = 0; i < 3; i++) step(1'b0, v_mem(1'b0, 32'd1), "load_mem_wait");
    step(1'b1, v_mem(1'b0, 32'd1), "load_mem_ack");
    step(1'b0, v_wb(1'b1, 2'd1, 2'd0, 32'd1), "load_wb");

    // Branches: taken, then not taken; the live comparator is inverted in WB.
    run_reg(7'b1100011, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 32'd2, "beq_taken");
    run_reg(7'b1100011, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd3, "beq_not");
    run_reg(7'b1101111, 1'b0, 1'b1, 1'b1, 2'd2, 2'd1, 32'd4, "jal");
    run_reg(7'b1100111, 1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 32'd5, "jalr");
    run_reg(7'b0110111, 1'b0, 1'b1, 1'b1, 2'd3, 2'd0, 32'd6, "lui");

    // Illegal opcode: trap after DEC2, stuck with no strobes, acks ignored.
    i_opcode = 7'b1111111;
    step(1'b1, v_fetch(1'b1, 32'd7), "ill_fetch");
    step(1'b0, v_zero(32'd7), "ill_dec1");
    step(1'b0, v_zero(32'd7), "ill_dec2");
    for (int i = 0; i < 20; i++) step(1'(i % 2), v_trap(32'd7), "ill_trap");
    if (o_fault !== 1'b1) begin
      miscompares++;
      $display("FAIL ill_fault_sticky: o_fault=%b", o_fault);
    end
    i_rst = 1'b1;
    step(1'b0, v_zero(32'd0), "ill_rst_async");
    if (o_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL ill_fault_clear: o_fault=%b", o_fault);
    end
    step(1'b0, v_zero(32'd0), "ill_rst_hold");
    i_rst = 1'b0;
    step(1'b0, v_zero(32'd0), "ill_reset_state");
    step(1'b0, v_fetch(1'b0, 32'd0), "ill_refetch");

    // STORE interrupted by reset in MEM.
    i_opcode = 7'b0100011;
    step(1'b1, v_fetch(1'b1, 32'd0), "st_fetch");
    step(1'b0, v_zero(32'd0), "st_dec1");
    step(1'b0, v_zero(32'd0), "st_dec2");
    step(1'b0, v_exec(1'b1, 32'd0), "st_exec");
    step(1'b0, v_mem(1'b1, 32'd0), "st_mem0");
    step(1'b0, v_mem(1'b1, 32'd0), "st_mem1");
    i_rst = 1'b1;
    #1;
    if (o_mem_req !== 1'b0 || o_mem_we !== 1'b0 || o_addr_sel !== 1'b0 ||
        o_rf_load !== 1'b0 || o_pc_load !== 1'b0) begin
      miscompares++;
      $display("FAIL st_rst_immediate: req=%b we=%b asel=%b rf=%b pcl=%b",
               o_mem_req, o_mem_we, o_addr_sel, o_rf_load, o_pc_load);
    end
    step(1'b0, v_zero(32'd0), "st_rst_async");
    i_rst = 1'b0;
    step(1'b0, v_zero(32'd0), "st_reset_state");
    step(1'b0, v_fetch(1'b0, 32'd0), "st_refetch");
    step(1'b0, v_fetch(1'b0, 32'd0), "st_refetch_hold");

    @(negedge i_clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL queue: %0d vectors never compared", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0) $display("TEST FAILED");
    else                  $display("TEST PASSED");
    $finish;
  end

endmodule
